// File: rtl/delay_sum_beamformer_v2_pkg.sv
// delay_sum_beamformer_v2_pkg: shared defaults, FSM states and output saturation helper
package delay_sum_beamformer_v2_pkg;
    localparam int BF_NUM_MICS = 9;
    localparam int BF_DATA_W   = 16;
    localparam int BF_DEPTH    = 256;
    localparam int BF_SHIFT    = 4;
    localparam int BF_DLY_W    = $clog2(BF_DEPTH);
    localparam int BF_IDX_W    = $clog2(BF_NUM_MICS);
    localparam int BF_ACC_W    = BF_DATA_W + $clog2(BF_NUM_MICS) + 1;

    typedef enum logic [1:0] {IDLE, RD, OUT} state_t;

    typedef struct packed {
        logic               sat;
        logic signed [63:0] val;
    } sat_t;

    function automatic sat_t sat_shift(input logic signed [63:0] acc, input int shift, input int data_w);
        logic signed [63:0] s, hi, lo;
        sat_t r;
        s = acc >>> shift;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        r.sat = (s > hi) || (s < lo);
        r.val = (s > hi) ? hi : (s < lo) ? lo : s;
        return r;
    endfunction
endpackage

// File: rtl/delay_sum_beamformer_v2_if.sv
// delay_sum_beamformer_v2_if: sample, delay-table and output bus of the beamformer
interface delay_sum_beamformer_v2_if
    import delay_sum_beamformer_v2_pkg::*;
#(
    parameter int NUM_MICS = BF_NUM_MICS,
    parameter int DATA_W   = BF_DATA_W,
    parameter int DEPTH    = BF_DEPTH
);
    localparam int DLY_W = $clog2(DEPTH);
    localparam int IDX_W = $clog2(NUM_MICS);
    logic                       in_valid;
    logic                       in_ready;
    logic [NUM_MICS*DATA_W-1:0] in_data;
    logic                       dly_wr_en;
    logic [IDX_W-1:0]           dly_wr_addr;
    logic [DLY_W-1:0]           dly_wr_data;
    logic [NUM_MICS-1:0]        ch_mask;
    logic                       commit;
    logic                       commit_done;
    logic                       out_valid;
    logic [DATA_W-1:0]          out_data;
    logic                       out_sat;
    modport master (
        output in_valid, in_data, dly_wr_en, dly_wr_addr, dly_wr_data, ch_mask, commit,
        input  in_ready, commit_done, out_valid, out_data, out_sat
    );
    modport slave (
        input  in_valid, in_data, dly_wr_en, dly_wr_addr, dly_wr_data, ch_mask, commit,
        output in_ready, commit_done, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/delay_sum_beamformer_v2_mic_delay_line.sv
// delay_sum_beamformer_v2_mic_delay_line: per-mic circular sample buffer, 1-cycle registered read
module delay_sum_beamformer_v2_mic_delay_line #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/delay_sum_beamformer_v2.sv
// delay_sum_beamformer_v2: delay-and-sum beamformer with double-buffered delays/mask and serial accumulation
module delay_sum_beamformer_v2
    import delay_sum_beamformer_v2_pkg::*;
#(
    parameter int NUM_MICS = BF_NUM_MICS,
    parameter int DATA_W   = BF_DATA_W,
    parameter int DEPTH    = BF_DEPTH,
    parameter int SHIFT    = BF_SHIFT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    delay_sum_beamformer_v2_if.slave    bus
);
    localparam int DLY_W = $clog2(DEPTH);
    localparam int IDX_W = $clog2(NUM_MICS);
    localparam int ACC_W = DATA_W + $clog2(NUM_MICS) + 1;
    localparam int CNT_W = $clog2(NUM_MICS + 1);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DLY_W-1:0]         wr_ptr_q, wr_ptr_d, cur_ptr_q, cur_ptr_d;
    logic [DLY_W:0]           fill_q, fill_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     acc_en_q, acc_en_d;
    logic [IDX_W-1:0]         acc_idx_q, acc_idx_d;
    logic [DLY_W-1:0]         dly_sh_q [NUM_MICS];
    logic [DLY_W-1:0]         dly_sh_d [NUM_MICS];
    logic [DLY_W-1:0]         dly_act_q [NUM_MICS];
    logic [DLY_W-1:0]         dly_act_d [NUM_MICS];
    logic [NUM_MICS-1:0]      mask_sh_q, mask_sh_d, mask_act_q, mask_act_d;
    logic                     pend_q, pend_d;
    logic                     hs, apply;
    logic [DATA_W-1:0]        rd_data [NUM_MICS];
    sat_t                     sr;
    logic [63-DATA_W:0]       sat_unused;

    for (genvar m = 0; m < NUM_MICS; m++) begin : g_mic
        delay_sum_beamformer_v2_mic_delay_line #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_line (
            .clk   (clk),
            .we    (hs),
            .waddr (wr_ptr_q),
            .wdata (bus.in_data[m*DATA_W +: DATA_W]),
            .raddr (cur_ptr_q - dly_act_q[m]),
            .rdata (rd_data[m])
        );
    end

    always_comb begin
        hs = bus.in_valid && state_q == IDLE;
        apply = pend_q && state_q == IDLE && !hs;
        state_d = state_q;
        cnt_d = cnt_q;
        wr_ptr_d = wr_ptr_q;
        cur_ptr_d = cur_ptr_q;
        fill_d = fill_q;
        acc_d = acc_q;
        dly_sh_d = dly_sh_q;
        dly_act_d = dly_act_q;
        mask_sh_d = mask_sh_q;
        mask_act_d = mask_act_q;
        pend_d = pend_q;
        if (bus.dly_wr_en && int'(bus.dly_wr_addr) < NUM_MICS) dly_sh_d[bus.dly_wr_addr] = bus.dly_wr_data;
        if (apply) begin
            dly_act_d = dly_sh_q;
            mask_act_d = mask_sh_q;
            pend_d = 1'b0;
        end
        // a pulse landing on the apply cycle stays pending for the next idle slot
        if (bus.commit) begin
            pend_d = 1'b1;
            mask_sh_d = bus.ch_mask;
        end
        if (hs) begin
            state_d = RD;
            cnt_d = '0;
            cur_ptr_d = wr_ptr_q;
            wr_ptr_d = wr_ptr_q + 1'b1;
            fill_d = (int'(fill_q) == DEPTH) ? fill_q : fill_q + 1'b1;
            acc_d = '0;
        end else if (state_q == RD) begin
            cnt_d = cnt_q + 1'b1;
            state_d = (int'(cnt_q) == NUM_MICS) ? OUT : RD;
        end else if (state_q == OUT) begin
            state_d = IDLE;
        end
        acc_en_d = state_q == RD && int'(cnt_q) < NUM_MICS;
        acc_idx_d = cnt_q[IDX_W-1:0];
        if (acc_en_q && mask_act_q[acc_idx_q] && fill_q > {1'b0, dly_act_q[acc_idx_q]})
            acc_d = acc_q + ACC_W'(signed'(rd_data[acc_idx_q]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            wr_ptr_q <= '0;
            cur_ptr_q <= '0;
            fill_q <= '0;
            acc_q <= '0;
            acc_en_q <= 1'b0;
            acc_idx_q <= '0;
            dly_sh_q <= '{default: '0};
            dly_act_q <= '{default: '0};
            mask_sh_q <= '0;
            mask_act_q <= '1;
            pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            cur_ptr_q <= cur_ptr_d;
            fill_q <= fill_d;
            acc_q <= acc_d;
            acc_en_q <= acc_en_d;
            acc_idx_q <= acc_idx_d;
            dly_sh_q <= dly_sh_d;
            dly_act_q <= dly_act_d;
            mask_sh_q <= mask_sh_d;
            mask_act_q <= mask_act_d;
            pend_q <= pend_d;
        end
    end

    assign sr = sat_shift(64'(acc_q), SHIFT, DATA_W);
    assign sat_unused = sr.val[63:DATA_W];
    assign bus.in_ready = state_q == IDLE;
    assign bus.commit_done = apply;
    assign bus.out_valid = state_q == OUT;
    assign bus.out_data = (state_q == OUT) ? sr.val[DATA_W-1:0] : '0;
    assign bus.out_sat = (state_q == OUT) && sr.sat;
endmodule

// File: tb/tb_delay_sum_beamformer_v2.sv
// tb_delay_sum_beamformer_v2: directed vectors on a SHIFT=2 and a SHIFT=0 instance fed identically
module tb_delay_sum_beamformer_v2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    delay_sum_beamformer_v2_if #(.NUM_MICS(4), .DATA_W(8), .DEPTH(16)) bus0 ();
    delay_sum_beamformer_v2_if #(.NUM_MICS(4), .DATA_W(8), .DEPTH(16)) bus1 ();

    assign bus1.in_valid = bus0.in_valid;
    assign bus1.in_data = bus0.in_data;
    assign bus1.dly_wr_en = bus0.dly_wr_en;
    assign bus1.dly_wr_addr = bus0.dly_wr_addr;
    assign bus1.dly_wr_data = bus0.dly_wr_data;
    assign bus1.ch_mask = bus0.ch_mask;
    assign bus1.commit = bus0.commit;

    delay_sum_beamformer_v2 #(.NUM_MICS(4), .DATA_W(8), .DEPTH(16), .SHIFT(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    delay_sum_beamformer_v2 #(.NUM_MICS(4), .DATA_W(8), .DEPTH(16), .SHIFT(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic wait_ready();
        int w = 0;
        while (!bus0.in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic xfer(input logic [31:0] d, output int o0, output int s0, output int o1, output int s1, output int lat);
        wait_ready();
        bus0.in_valid = 1'b1;
        bus0.in_data = d;
        @(posedge clk);
        #1 bus0.in_valid = 1'b0;
        lat = -1; o0 = 0; s0 = 0; o1 = 0; s1 = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus0.out_valid) begin
                lat = c;
                o0 = int'($signed(bus0.out_data));
                s0 = int'(bus0.out_sat);
                o1 = int'($signed(bus1.out_data));
                s1 = int'(bus1.out_sat);
                break;
            end
        end
    endtask

    task automatic send_chk(input string tag, input logic [31:0] d, input int exp);
        int o0, s0, o1, s1, lat;
        xfer(d, o0, s0, o1, s1, lat);
        check({tag, "_out"}, o0, exp);
        check({tag, "_lat"}, lat, 6);
    endtask

    task automatic set_dly(input int m, input int d);
        bus0.dly_wr_en = 1'b1;
        bus0.dly_wr_addr = 2'(m);
        bus0.dly_wr_data = 4'(d);
        @(posedge clk);
        #1 bus0.dly_wr_en = 1'b0;
    endtask

    task automatic do_commit(input logic [3:0] mask);
        int w = 0;
        bus0.ch_mask = mask;
        bus0.commit = 1'b1;
        @(posedge clk);
        #1 bus0.commit = 1'b0;
        while (!bus0.commit_done && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("commit_done", int'(bus0.commit_done), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int o0, s0, o1, s1, lat, ov, cd, seen;
        logic [31:0] d;
        bus0.in_valid = 1'b0;
        bus0.in_data = '0;
        bus0.dly_wr_en = 1'b0;
        bus0.dly_wr_addr = '0;
        bus0.dly_wr_data = '0;
        bus0.ch_mask = '0;
        bus0.commit = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(bus0.in_ready), 1);
        check("rst_out_valid", int'(bus0.out_valid), 0);
        check("rst_commit_done", int'(bus0.commit_done), 0);
        check("rst_out_data", int'(bus0.out_data), 0);
        check("rst_out_sat", int'(bus0.out_sat), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // impulse: mic n picks up the shared impulse on sample n
        for (int m = 0; m < 4; m++) set_dly(m, m);
        do_commit(4'hF);
        for (int n = 0; n < 6; n++)
            send_chk("impulse", (n == 0) ? pk(100, 100, 100, 100) : 32'h0, (n < 4) ? 25 : 0);

        for (int n = 0; n < 7; n++) begin
            d = '0;
            for (int m = 0; m < 4; m++) if (n == 3 - m) d[m*8 +: 8] = 8'd100;
            send_chk("align", d, (n == 3) ? 100 : 0);
        end

        // commit raised during RD must wait for the in-flight sample
        for (int k = 0; k < 5; k++) xfer(pk(8*k, 8*k+1, 8*k+2, 8*k+3), o0, s0, o1, s1, lat);
        for (int m = 0; m < 4; m++) set_dly(m, 2);
        wait_ready();
        bus0.in_valid = 1'b1;
        bus0.in_data = pk(40, 41, 42, 43);
        @(posedge clk);
        #1 bus0.in_valid = 1'b0;
        bus0.ch_mask = 4'hF;
        bus0.commit = 1'b1;
        @(posedge clk);
        #1 bus0.commit = 1'b0;
        ov = -1; cd = -1; o0 = 0;
        for (int c = 2; c <= 14; c++) begin
            @(negedge clk);
            if (bus0.out_valid) begin
                ov = c;
                o0 = int'($signed(bus0.out_data));
            end
            if (bus0.commit_done) cd = c;
        end
        check("defer_out_lat", ov, 6);
        check("defer_done_lat", cd, 7);
        check("defer_old_dly", o0, 29);
        send_chk("defer_new_dly", pk(48, 49, 50, 51), 33);

        do_reset();
        xfer(pk(127, 127, 127, 127), o0, s0, o1, s1, lat);
        check("pos_s2_out", o0, 127);
        check("pos_s2_sat", s0, 0);
        check("pos_s0_out", o1, 127);
        check("pos_s0_sat", s1, 1);
        xfer(pk(-128, -128, -128, -128), o0, s0, o1, s1, lat);
        check("neg_s2_out", o0, -128);
        check("neg_s2_sat", s0, 0);
        check("neg_s0_out", o1, -128);
        check("neg_s0_sat", s1, 1);

        wait_ready();
        bus0.in_valid = 1'b1;
        bus0.in_data = pk(50, 50, 50, 50);
        @(posedge clk);
        #1 bus0.in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", int'(bus0.in_ready), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus0.out_valid) seen++;
        end
        check("midrst_no_out", seen, 0);
        check("midrst_ready", int'(bus0.in_ready), 1);
        send_chk("midrst_first", pk(20, 20, 20, 20), 20);

        // mic 0 alone with the longest delay, across two pointer wraps
        do_reset();
        set_dly(0, 15);
        do_commit(4'b0001);
        for (int n = 0; n < 40; n++)
            send_chk("wrap", pk(3*n - 50, n, 7, -9), (n < 15) ? 0 : ((3*(n-15) - 50) >>> 2));
        do_commit(4'b0000);
        xfer(pk(100, 100, 100, 100), o0, s0, o1, s1, lat);
        check("mask0_out", o0, 0);
        check("mask0_sat", s0, 0);
        check("mask0_lat", lat, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
